// File: rtl/seq_pkg.sv
// Shared definitions for the serial frame generator: default sizes and FSM encoding.
package seq_pkg;

  localparam int WIDTH_DEF = 16;
  localparam int CNT_W_DEF = $clog2(WIDTH_DEF + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/seq_shreg.sv
// Loadable right-shift register; lsb_o is the bit that will be presented next.
module seq_shreg
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             lsb_o
);

  logic [WIDTH-1:0] sr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q <= '0;
    end else if (load_i) begin
      sr_q <= din_i;
    end else if (shift_i) begin
      sr_q <= {1'b0, sr_q[WIDTH-1:1]};
    end
  end

  assign lsb_o = sr_q[0];

endmodule

// File: rtl/seq_gen.sv
// Serial frame generator: sends nbits of data LSB first, repeated rep+1 times,
// then pulses done. Every output comes straight from a flop.
module seq_gen
  import seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] data,
  input  logic [CNT_W-1:0] nbits,
  input  logic [3:0]       rep,
  output logic             ready,
  output logic             out,
  output logic             out_valid,
  output logic             done
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, load_val;
  logic [CNT_W-1:0] nb_q, cnt_q, nb_eff;
  logic [3:0]       rep_q;
  logic             accept, last_bit, reload, sr_load, sr_shift, sr_lsb, nxt_bit;
  logic             ready_q, out_q, vld_q, done_q;
  logic             ready_d, out_d, vld_d, done_d;

  assign nb_eff   = (nbits == '0 || nbits > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : nbits;
  assign accept   = (state_q == IDLE) && start;
  assign last_bit = (cnt_q == nb_q - CNT_W'(1));
  assign reload   = (state_q == SHIFT) && last_bit && (rep_q != 4'd0);
  assign sr_shift = (state_q == SHIFT) && !last_bit;
  assign sr_load  = accept || reload;
  assign load_val = accept ? data : data_q;
  // The register holds the bits after the one currently on out, so bit 0 bypasses it.
  assign nxt_bit  = sr_load ? load_val[0] : sr_lsb;

  seq_shreg #(.WIDTH(WIDTH)) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .din_i   ({1'b0, load_val[WIDTH-1:1]}),
    .lsb_o   (sr_lsb)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit && rep_q == 4'd0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they line up with state_q.
  always_comb begin
    ready_d = (state_d == IDLE);
    vld_d   = (state_d == SHIFT);
    done_d  = (state_d == DONE);
    out_d   = vld_d && nxt_bit;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ready_q <= 1'b1;
      out_q   <= 1'b0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      ready_q <= ready_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      nb_q   <= '0;
      cnt_q  <= '0;
      rep_q  <= '0;
    end else if (accept) begin
      data_q <= data;
      nb_q   <= nb_eff;
      cnt_q  <= '0;
      rep_q  <= rep;
    end else if (reload) begin
      cnt_q  <= '0;
      rep_q  <= rep_q - 4'd1;
    end else if (sr_shift) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign ready     = ready_q;
  assign out       = out_q;
  assign out_valid = vld_q;
  assign done      = done_q;

endmodule

// File: doc/seq_gen.md
SEQ_GEN -- requirements
Module: seq_gen

Interface
REQ-001 The module SHALL have one clock, clk; rst SHALL be synchronous and active-high.
REQ-002 Parameter WIDTH, default 16: maximum frame length in bits.
REQ-003 Parameter CNT_W, default 5: counter width, equal to clog2(WIDTH+1).
REQ-004 Port clk, input, 1 bit: rising-edge clock.
REQ-005 Port rst, input, 1 bit: synchronous active-high reset.
REQ-006 Port start, input, 1 bit: request to transmit a frame; accepted only when ready=1.
REQ-007 Port data, input, WIDTH bits: frame payload, transmitted LSB first (bit 0 first).
REQ-008 Port nbits, input, CNT_W bits: frame length; valid range 1..WIDTH; 0 or any value >WIDTH SHALL be treated as WIDTH.
REQ-009 Port rep, input, 4 bits: number of additional repetitions of the frame (0..15).
REQ-010 Port ready, output, 1 bit: high only in IDLE.
REQ-011 Port out, output, 1 bit: serial bit stream, intended to drive a seq_detect input directly.
REQ-012 Port out_valid, output, 1 bit: out carries a payload bit this cycle.
REQ-013 Port done, output, 1 bit: one-cycle pulse after the last bit of the last repetition.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-015 In IDLE, when start=1 is sampled, the block SHALL capture data, the effective nbits and rep, and move to SHIFT.
REQ-016 The first bit, data[0], SHALL appear on out with out_valid=1 in the cycle immediately after the accepting edge (latency 1).
REQ-017 In SHIFT, the block SHALL present one bit per cycle, bit i in the i-th SHIFT cycle of a repetition, with out_valid=1 continuously and no gaps between repetitions.
REQ-018 On the last bit of a repetition with the repeat count greater than 0, the block SHALL reload the captured data, clear the bit counter, decrement the repeat count and stay in SHIFT.
REQ-019 On the last bit with the repeat count equal to 0, the next state SHALL be DONE.
REQ-020 The total out_valid cycles per accepted start SHALL be nbits_eff*(rep+1).
REQ-021 In DONE, for exactly one cycle, the block SHALL drive done=1, out_valid=0, out=0 and ready=0; it SHALL then return to IDLE.
REQ-022 When out_valid=0, out SHALL be 0.
REQ-023 start SHALL be ignored in SHIFT and DONE; the captured data, nbits and rep SHALL not change while a frame is in progress.
REQ-024 All outputs SHALL be registered, with no combinational path from input to output.
REQ-025 A start sampled in the same cycle that DONE returns to IDLE SHALL not be accepted; acceptance requires ready=1 in that cycle.

Reset
REQ-026 When rst=1 is sampled, the next cycle SHALL have state=IDLE, ready=1, out=0, out_valid=0, done=0, and counters and the shift register cleared.
REQ-027 Reset mid-frame SHALL abort the frame with no done pulse; rst SHALL take priority over start.

Structure
REQ-028 A shared package seq_pkg SHALL hold the WIDTH default, CNT_W and the state encoding (IDLE=0, SHIFT=1, DONE=2).
REQ-029 One sub-module is natural: seq_shreg, a WIDTH-bit loadable right-shift register with load and shift enables; the FSM and counters SHALL stay in seq_gen.

Verification
REQ-030 data=16'b1110101111011001, nbits=16, rep=0 -> out=1,0,0,1,1,0,1,1,1,1,0,1,0,1,1,1 over 16 valid cycles, then done=1 for one cycle, then ready=1.
REQ-031 data=16'h0005, nbits=4, rep=2 -> 1,0,1,0 repeated 3 times (12 consecutive valid cycles), then done in cycle 13.
REQ-032 nbits=0 with data=16'hFFFF -> exactly 16 valid cycles of out=1.
REQ-033 start pulsed during SHIFT with different data -> the stream is unchanged, and the second start is not accepted until ready=1.
REQ-034 rst asserted at bit 7 of a 16-bit frame -> next cycle out_valid=0, ready=1, no done pulse; a new start then transmits from bit 0.
REQ-035 seq_gen.out driving seq_detect.in (one bit per clk) -> detector output matches a golden model of the same bit stream.
